// File: rtl/i2s_rx_pkg.sv
// I2S receive framing package.
// Shared state encoding, error counter width and the bit-counter width
// helper used by the receive frame controller.
package i2s_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        TRAIN,
        LOCKED,
        DRAIN
    } rx_state_t;

    localparam int ERR_CNT_W = 8;

    // Counter must hold 0..slot_width; slot_width itself marks "unsynced".
    function automatic int cnt_w(input int slot_width);
        return $clog2(slot_width + 1);
    endfunction

endpackage

// File: rtl/i2s_lr_edge_det.sv
// LRCLK / DATA input stage with word-select edge detection.
// Registers LRCLK and DATA on posedge i2s_bclk and flags LRCLK transitions.
// Shared with the TX framer, so it carries no RX-specific logic.
//
// Ports:
//   i2s_bclk   in   bit clock
//   sys_rst    in   asynchronous active-high reset
//   i2s_lrclk  in   word select
//   i2s_data   in   serial data
//   lr_r       out  registered word select
//   dat_r      out  registered serial data
//   lr_edge    out  lr_r differs from its previous value
//   lr_fall    out  lr_edge with lr_r == 0 (start of a left half-frame)
module i2s_lr_edge_det (
    input  logic i2s_bclk,
    input  logic sys_rst,
    input  logic i2s_lrclk,
    input  logic i2s_data,
    output logic lr_r,
    output logic dat_r,
    output logic lr_edge,
    output logic lr_fall
);

    logic lr_p;

    always_ff @(posedge i2s_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            lr_r  <= 1'b0;
            lr_p  <= 1'b0;
            dat_r <= 1'b0;
        end else begin
            lr_r  <= i2s_lrclk;
            lr_p  <= lr_r;
            dat_r <= i2s_data;
        end
    end

    assign lr_edge = lr_r ^ lr_p;
    assign lr_fall = lr_edge & ~lr_r;

endmodule

// File: rtl/i2s_rx_frame_ctrl.sv
// I2S receive framing controller (i2s_bclk domain).
// Locks onto LRCLK half-frame boundaries, checks slot length and produces
// zero-latency shift / word-complete strobes aligned with rx_bit. Strobes
// are only issued while locked so misframed words never reach the FIFOs.
//
// Optional feature: define I2S_RX_ERR_CNT_EN to add the saturating
// err_cnt output (frame errors since reset).
//
// Ports:
//   i2s_bclk     in   bit clock, all logic on posedge
//   sys_rst      in   asynchronous active-high reset
//   i2s_lrclk    in   word select (0 = left)
//   i2s_data     in   serial data
//   enable       in   run request
//   rx_bit       out  registered serial data
//   shift_en     out  rx_bit is a payload bit
//   word_done    out  rx_bit is the word LSB
//   word_lr      out  channel of the current word (0 = L)
//   frame_start  out  rx_bit is the MSB of a left word
//   locked       out  controller in LOCKED or DRAIN
//   frame_err    out  one-cycle pulse on slot-length violation
//   err_cnt      out  [7:0] saturating error count (I2S_RX_ERR_CNT_EN only)
//
// state  | meaning
// IDLE   | stopped, no strobes
// SEEK   | waiting for a falling LRCLK edge
// TRAIN  | counting good half-frames before lock
// LOCKED | framing good, strobes active
// DRAIN  | enable dropped, finishing the in-flight word
module i2s_rx_frame_ctrl
    import i2s_rx_pkg::*;
#(
    parameter int I2S_WIDTH   = 24,
    parameter int SLOT_WIDTH  = 32,
    parameter int LOCK_FRAMES = 2
) (
    input  logic i2s_bclk,
    input  logic sys_rst,
    input  logic i2s_lrclk,
    input  logic i2s_data,
    input  logic enable,
`ifdef I2S_RX_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic rx_bit,
    output logic shift_en,
    output logic word_done,
    output logic word_lr,
    output logic frame_start,
    output logic locked,
    output logic frame_err
);

    localparam int CW = cnt_w(SLOT_WIDTH);
    localparam int GW = $clog2(2 * LOCK_FRAMES + 1);
    localparam logic [CW-1:0] SLOT_MAX  = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_WIDTH - 1);
    localparam logic [CW-1:0] WORD_LEN  = CW'(I2S_WIDTH);
    localparam logic [CW-1:0] WORD_LAST = CW'(I2S_WIDTH - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(2 * LOCK_FRAMES - 1);

    logic          lr_r;
    logic          dat_r;
    logic          lr_edge;
    logic          lr_fall;
    logic [CW-1:0] bit_cnt;
    logic          slot_lr;
    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [GW-1:0] good_cnt;
    logic [GW-1:0] good_nxt;
    logic          chk_active;
    logic          slot_err;
    logic          good_edge;
    logic          run;
    logic          strobe_ok;

    i2s_lr_edge_det u_edge (
        .i2s_bclk  (i2s_bclk),
        .sys_rst   (sys_rst),
        .i2s_lrclk (i2s_lrclk),
        .i2s_data  (i2s_data),
        .lr_r      (lr_r),
        .dat_r     (dat_r),
        .lr_edge   (lr_edge),
        .lr_fall   (lr_fall)
    );

    // bit_cnt == 0 is the cycle after the edge (I2S one-bit delay, MSB).
    always_ff @(posedge i2s_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            bit_cnt <= SLOT_MAX;
            slot_lr <= 1'b0;
        end else if (lr_edge) begin
            bit_cnt <= '0;
            slot_lr <= lr_r;
        end else if (bit_cnt != SLOT_MAX) begin
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    // Edge away from the last slot bit is early; last bit without edge is late.
    assign chk_active = (state == TRAIN) || (state == LOCKED) || (state == DRAIN);
    assign slot_err   = chk_active && (lr_edge != (bit_cnt == SLOT_LAST));
    assign good_edge  = lr_edge && (bit_cnt == SLOT_LAST);
    assign run        = (state == LOCKED) || (state == DRAIN);
    assign strobe_ok  = run && !slot_err;

    always_ff @(posedge i2s_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // Errors are tested before enable so a simultaneous drop still reports.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        case (state)
            IDLE: begin
                if (enable) state_nxt = SEEK;
            end
            SEEK: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (lr_fall) begin
                    state_nxt = TRAIN;
                    good_nxt  = '0;
                end
            end
            TRAIN: begin
                if (slot_err) begin
                    state_nxt = SEEK;
                end else if (!enable) begin
                    state_nxt = IDLE;
                end else if (good_edge) begin
                    // Even count of half-frames from a falling edge: lock lands on a falling edge.
                    if (good_cnt == GOOD_LAST) state_nxt = LOCKED;
                    else good_nxt = good_cnt + GW'(1);
                end
            end
            LOCKED: begin
                if (slot_err) state_nxt = SEEK;
                else if (!enable) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (slot_err || lr_edge) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_bit      = dat_r;
    assign shift_en    = strobe_ok && (bit_cnt < WORD_LEN);
    assign word_done   = strobe_ok && (bit_cnt == WORD_LAST);
    assign word_lr     = strobe_ok && slot_lr;
    assign frame_start = strobe_ok && (bit_cnt == '0) && !slot_lr;
    assign locked      = run;
    assign frame_err   = slot_err;

`ifdef I2S_RX_ERR_CNT_EN
    always_ff @(posedge i2s_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            err_cnt <= '0;
        end else if (slot_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// Directed bench for i2s_rx_frame_ctrl. A 24-bit instance is the main DUT;
// a 32-bit-payload instance on the same stimulus covers the LSB-at-last-bit
// case. Stimulus is driven on negedge, outputs sampled 1 time unit after posedge.
module tb_i2s_rx_frame_ctrl;

    logic i2s_bclk = 1'b0;
    logic sys_rst  = 1'b1;
    logic i2s_lrclk = 1'b1;
    logic i2s_data  = 1'b1;
    logic enable    = 1'b0;

    logic rx_bit, shift_en, word_done, word_lr, frame_start, locked, frame_err;
    logic rx_bit_32, shift_en_32, word_done_32, word_lr_32, frame_start_32, locked_32, frame_err_32;
`ifdef I2S_RX_ERR_CNT_EN
    logic [7:0] err_cnt, err_cnt_32;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 i2s_bclk = ~i2s_bclk;

    i2s_rx_frame_ctrl #(.I2S_WIDTH(24), .SLOT_WIDTH(32), .LOCK_FRAMES(2)) dut (
        .i2s_bclk    (i2s_bclk),
        .sys_rst     (sys_rst),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_data    (i2s_data),
        .enable      (enable),
`ifdef I2S_RX_ERR_CNT_EN
        .err_cnt     (err_cnt),
`endif
        .rx_bit      (rx_bit),
        .shift_en    (shift_en),
        .word_done   (word_done),
        .word_lr     (word_lr),
        .frame_start (frame_start),
        .locked      (locked),
        .frame_err   (frame_err)
    );

    i2s_rx_frame_ctrl #(.I2S_WIDTH(32), .SLOT_WIDTH(32), .LOCK_FRAMES(2)) dut32 (
        .i2s_bclk    (i2s_bclk),
        .sys_rst     (sys_rst),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_data    (i2s_data),
        .enable      (enable),
`ifdef I2S_RX_ERR_CNT_EN
        .err_cnt     (err_cnt_32),
`endif
        .rx_bit      (rx_bit_32),
        .shift_en    (shift_en_32),
        .word_done   (word_done_32),
        .word_lr     (word_lr_32),
        .frame_start (frame_start_32),
        .locked      (locked_32),
        .frame_err   (frame_err_32)
    );

    // Monitor: reassembles words and counts pulses.
    logic [24:0] wq[$];
    int          lq[$];
    logic [23:0] sh = '0;
    int sc = 0, fe_cnt = 0, fs_cnt = 0, stb_cnt = 0, wd32_cnt = 0, fe32_cnt = 0;

    initial forever begin
        @(posedge i2s_bclk);
        #1;
        if (frame_err) fe_cnt++;
        if (frame_err_32) fe32_cnt++;
        if (frame_start) fs_cnt++;
        if (word_done_32) wd32_cnt++;
        if (shift_en || word_done || frame_start) stb_cnt++;
        if (!locked) sc = 0;
        if (shift_en) sc++;
        if (word_done) begin
            wq.push_back({word_lr, sh[22:0], rx_bit});
            lq.push_back(sc);
            sc = 0;
        end
        if (shift_en) sh = {sh[22:0], rx_bit};
    end

    function automatic logic slot_bit(input logic [23:0] w, input int j);
        if (j >= 1 && j <= 24) return w[24-j];
        return 1'b0;
    endfunction

    task automatic drive_bit(input logic lr, input logic d);
        @(negedge i2s_bclk);
        i2s_lrclk = lr;
        i2s_data  = d;
    endtask

    task automatic send_part(input logic lr, input logic [23:0] w, input int first, input int last);
        for (int j = first; j <= last; j++) drive_bit(lr, slot_bit(w, j));
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_part(1'b0, l, 0, 31);
        send_part(1'b1, r, 0, 31);
    endtask

    // Two training frames then a frame whose words are the first out after lock.
    task automatic lock_seq(input string tag, input logic [23:0] l, input logic [23:0] r);
        int i0;
        i0 = wq.size();
        send_frame(24'h0A0B0C, 24'h0D0E0F);
        send_frame(24'h102030, 24'h405060);
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL %s_prelock locked=%b want 0", tag, locked); end
        tests_run++;
        if (wq.size() - i0 !== 0) begin tests_failed++; $display("FAIL %s_train_words got=%0d want 0", tag, wq.size() - i0); end
        send_frame(l, r);
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL %s_lock locked=%b want 1", tag, locked); end
        tests_run++;
        if (wq.size() - i0 !== 2) begin tests_failed++; $display("FAIL %s_words got=%0d want 2", tag, wq.size() - i0); end
        tests_run++;
        if (wq[i0] !== {1'b0, l}) begin tests_failed++; $display("FAIL %s_L got=%h want %h", tag, wq[i0], {1'b0, l}); end
        tests_run++;
        if (wq[i0+1] !== {1'b1, r}) begin tests_failed++; $display("FAIL %s_R got=%h want %h", tag, wq[i0+1], {1'b1, r}); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i2s_bclk);
        tests_run++; if (rx_bit      !== 1'b0) begin tests_failed++; $display("FAIL rst_rx_bit got=%b want 0", rx_bit); end
        tests_run++; if (shift_en    !== 1'b0) begin tests_failed++; $display("FAIL rst_shift_en got=%b want 0", shift_en); end
        tests_run++; if (word_done   !== 1'b0) begin tests_failed++; $display("FAIL rst_word_done got=%b want 0", word_done); end
        tests_run++; if (word_lr     !== 1'b0) begin tests_failed++; $display("FAIL rst_word_lr got=%b want 0", word_lr); end
        tests_run++; if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL rst_frame_start got=%b want 0", frame_start); end
        tests_run++; if (locked      !== 1'b0) begin tests_failed++; $display("FAIL rst_locked got=%b want 0", locked); end
        tests_run++; if (frame_err   !== 1'b0) begin tests_failed++; $display("FAIL rst_frame_err got=%b want 0", frame_err); end
`ifdef I2S_RX_ERR_CNT_EN
        tests_run++; if (err_cnt !== 8'd0) begin tests_failed++; $display("FAIL rst_err_cnt got=%0d want 0", err_cnt); end
`endif
        sys_rst  = 1'b0;
        i2s_data = 1'b0;
        enable   = 1'b1;
        repeat (4) drive_bit(1'b1, 1'b0);
    endtask

    task automatic test_clean();
        int i0, f0, fs0, w0;
        logic [24:0] exp;
        i0 = wq.size(); f0 = fe_cnt; fs0 = fs_cnt; w0 = wd32_cnt;
        send_frame(24'hA5A5A5, 24'h5A5A5A);
        send_frame(24'hA5A5A5, 24'h5A5A5A);
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL clean_prelock locked=%b want 0", locked); end
        repeat (3) send_frame(24'hA5A5A5, 24'h5A5A5A);
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL clean_lock locked=%b want 1", locked); end
        tests_run++;
        if (wq.size() - i0 !== 6) begin tests_failed++; $display("FAIL clean_words got=%0d want 6", wq.size() - i0); end
        for (int k = 0; k < 6; k++) begin
            exp = (k % 2 == 0) ? {1'b0, 24'hA5A5A5} : {1'b1, 24'h5A5A5A};
            tests_run++;
            if (wq[i0+k] !== exp) begin tests_failed++; $display("FAIL clean_word%0d got=%h want %h", k, wq[i0+k], exp); end
            tests_run++;
            if (lq[i0+k] !== 24) begin tests_failed++; $display("FAIL clean_shift_len%0d got=%0d want 24", k, lq[i0+k]); end
        end
        tests_run++;
        if (fs_cnt - fs0 !== 3) begin tests_failed++; $display("FAIL clean_frame_start got=%0d want 3", fs_cnt - fs0); end
        tests_run++;
        if (fe_cnt - f0 !== 0) begin tests_failed++; $display("FAIL clean_frame_err got=%0d want 0", fe_cnt - f0); end
        tests_run++;
        if (wd32_cnt - w0 !== 5) begin tests_failed++; $display("FAIL clean_wd32 got=%0d want 5", wd32_cnt - w0); end
    endtask

    task automatic test_short_slot();
        int f0, i1;
        f0 = fe_cnt;
        send_part(1'b0, 24'h123456, 0, 30);
        send_part(1'b1, 24'h654321, 0, 0);
        tests_run++;
        if (fe_cnt - f0 !== 0) begin tests_failed++; $display("FAIL short_err_early got=%0d want 0", fe_cnt - f0); end
        i1 = wq.size();
        send_part(1'b1, 24'h654321, 1, 1);
        tests_run++;
        if (fe_cnt - f0 !== 1) begin tests_failed++; $display("FAIL short_err_pulse got=%0d want 1", fe_cnt - f0); end
        send_part(1'b1, 24'h654321, 2, 31);
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL short_unlock locked=%b want 0", locked); end
        tests_run++;
        if (wq.size() - i1 !== 0) begin tests_failed++; $display("FAIL short_no_word got=%0d want 0", wq.size() - i1); end
        lock_seq("short_relock", 24'hC0FFEE, 24'hBEEF01);
        tests_run++;
        if (fe_cnt - f0 !== 1) begin tests_failed++; $display("FAIL short_err_total got=%0d want 1", fe_cnt - f0); end
    endtask

    task automatic test_long_slot();
        int f0, f320, i0, w0;
        f0 = fe_cnt; f320 = fe32_cnt; i0 = wq.size();
        send_part(1'b0, 24'h3C3C3C, 0, 1);
        w0 = wd32_cnt;
        send_part(1'b0, 24'h3C3C3C, 2, 32);
        tests_run++;
        if (fe_cnt - f0 !== 0) begin tests_failed++; $display("FAIL long_err_early got=%0d want 0", fe_cnt - f0); end
        send_part(1'b1, 24'h777000, 0, 0);
        tests_run++;
        if (fe_cnt - f0 !== 1) begin tests_failed++; $display("FAIL long_err_pulse got=%0d want 1", fe_cnt - f0); end
        tests_run++;
        if (fe32_cnt - f320 !== 1) begin tests_failed++; $display("FAIL long_err32_pulse got=%0d want 1", fe32_cnt - f320); end
        tests_run++;
        if (wd32_cnt - w0 !== 0) begin tests_failed++; $display("FAIL long_wd32_suppressed got=%0d want 0", wd32_cnt - w0); end
        tests_run++;
        if (wq[i0] !== {1'b0, 24'h3C3C3C}) begin tests_failed++; $display("FAIL long_word got=%h want %h", wq[i0], {1'b0, 24'h3C3C3C}); end
        send_part(1'b1, 24'h777000, 1, 31);
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL long_unlock locked=%b want 0", locked); end
`ifdef I2S_RX_ERR_CNT_EN
        tests_run++;
        if (err_cnt !== 8'd2) begin tests_failed++; $display("FAIL long_err_cnt got=%0d want 2", err_cnt); end
`endif
        lock_seq("long_relock", 24'h55AA33, 24'hCC0F81);
    endtask

    task automatic test_enable_drop();
        int i0, s0, f0;
        i0 = wq.size(); f0 = fe_cnt;
        send_part(1'b0, 24'h13579B, 0, 31);
        send_part(1'b1, 24'h2468AC, 0, 11);
        enable = 1'b0;
        send_part(1'b1, 24'h2468AC, 12, 31);
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("FAIL drain_locked locked=%b want 1", locked); end
        tests_run++;
        if (wq.size() - i0 !== 2) begin tests_failed++; $display("FAIL drain_words got=%0d want 2", wq.size() - i0); end
        tests_run++;
        if (wq[i0+1] !== {1'b1, 24'h2468AC}) begin tests_failed++; $display("FAIL drain_R_word got=%h want %h", wq[i0+1], {1'b1, 24'h2468AC}); end
        tests_run++;
        if (lq[i0+1] !== 24) begin tests_failed++; $display("FAIL drain_R_len got=%0d want 24", lq[i0+1]); end
        s0 = stb_cnt;
        send_part(1'b0, 24'hFFFFFF, 0, 31);
        tests_run++;
        if (locked !== 1'b0) begin tests_failed++; $display("FAIL drain_idle locked=%b want 0", locked); end
        tests_run++;
        if (stb_cnt - s0 !== 0) begin tests_failed++; $display("FAIL drain_no_strobes got=%0d want 0", stb_cnt - s0); end
        tests_run++;
        if (fe_cnt - f0 !== 0) begin tests_failed++; $display("FAIL drain_no_err got=%0d want 0", fe_cnt - f0); end
    endtask

    task automatic test_reset_mid_word();
        int i0;
        enable = 1'b1;
        send_part(1'b1, 24'h000000, 0, 31);
        lock_seq("pre_rst", 24'h777777, 24'h888888);
        i0 = wq.size();
        send_part(1'b0, 24'hABCDEF, 0, 14);
        tests_run++;
        if (shift_en !== 1'b1) begin tests_failed++; $display("FAIL midrst_shifting got=%b want 1", shift_en); end
        sys_rst = 1'b1;
        #1;
        tests_run++; if (rx_bit      !== 1'b0) begin tests_failed++; $display("FAIL midrst_rx_bit got=%b want 0", rx_bit); end
        tests_run++; if (shift_en    !== 1'b0) begin tests_failed++; $display("FAIL midrst_shift_en got=%b want 0", shift_en); end
        tests_run++; if (word_done   !== 1'b0) begin tests_failed++; $display("FAIL midrst_word_done got=%b want 0", word_done); end
        tests_run++; if (word_lr     !== 1'b0) begin tests_failed++; $display("FAIL midrst_word_lr got=%b want 0", word_lr); end
        tests_run++; if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL midrst_frame_start got=%b want 0", frame_start); end
        tests_run++; if (locked      !== 1'b0) begin tests_failed++; $display("FAIL midrst_locked got=%b want 0", locked); end
        tests_run++; if (frame_err   !== 1'b0) begin tests_failed++; $display("FAIL midrst_frame_err got=%b want 0", frame_err); end
        send_part(1'b0, 24'hABCDEF, 15, 16);
        sys_rst = 1'b0;
        send_part(1'b0, 24'hABCDEF, 17, 31);
        tests_run++;
        if (wq.size() - i0 !== 0) begin tests_failed++; $display("FAIL midrst_no_word got=%0d want 0", wq.size() - i0); end
        send_part(1'b1, 24'h000000, 0, 31);
        lock_seq("post_rst", 24'h010203, 24'h040506);
    endtask

`ifdef I2S_RX_ERR_CNT_EN
    // LRCLK toggling every 2 BCLKs: each falling edge enters TRAIN and the
    // next edge is early, giving one error per 4 cycles (about 300 total).
    task automatic test_err_cnt();
        for (int k = 0; k < 1240; k++) drive_bit(1'((k >> 1) & 1), 1'b0);
        tests_run++;
        if (err_cnt !== 8'd255) begin tests_failed++; $display("FAIL err_cnt_sat got=%0d want 255", err_cnt); end
        tests_run++;
        if (fe_cnt < 256) begin tests_failed++; $display("FAIL err_cnt_pulses got=%0d want >=256", fe_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean();
        test_short_slot();
        test_long_slot();
        test_enable_drop();
        test_reset_mid_word();
`ifdef I2S_RX_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/i2s_rx_frame_ctrl.md
Name: i2s_rx_frame_ctrl

Overview:
Framing controller for the I2S receive path, in the i2s_bclk domain. It registers LRCLK and DATA, locks onto the LRCLK half-frame boundaries, and checks slot length. It emits per-bit shift strobes, a word-complete strobe and the L/R tag to the receive shift register and latch ahead of the sys_clk CDC and the per-channel FIFOs. While unlocked or misframed, it suppresses all strobes so garbage words never reach the FIFOs.

Parameters:
I2S_WIDTH, 24, payload bits per word, MSB first; must be <= SLOT_WIDTH.
SLOT_WIDTH, 32, BCLK periods per LRCLK half-frame; legal range 8..32.
LOCK_FRAMES, 2, consecutive good stereo frames required before lock; legal range 1..15.

Ports:
i2s_bclk  in  1  bit clock; all logic on posedge
sys_rst  in  1  reset, asynchronous, active-high
i2s_lrclk  in  1  word select (0 = left)
i2s_data  in  1  serial data
enable  in  1  run request (quasi-static)
rx_bit  out  1  registered i2s_data, aligned with strobes
shift_en  out  1  rx_bit is a payload bit
word_done  out  1  rx_bit is the word LSB; the datapath latches {shift_reg, rx_bit}
word_lr  out  1  channel of the current word (0 = L, 1 = R)
frame_start  out  1  rx_bit is the MSB of a left word
locked  out  1  controller in LOCKED or DRAIN
frame_err  out  1  one-cycle pulse on a slot-length violation

Behaviour:
- Reset values: all outputs 0; internal lr_r/lr_p/dat_r = 0; bit_cnt = SLOT_WIDTH (unsynced); state = IDLE.
- Input stage: lr_r <= i2s_lrclk; dat_r <= i2s_data; lr_p <= lr_r; rx_bit = dat_r.
- Edge detection: edge = lr_r ^ lr_p; a falling edge has lr_r == 0.
- Bit counter: on edge, bit_cnt <= 0 and slot_lr <= lr_r. Otherwise bit_cnt increments, saturating at SLOT_WIDTH.
- I2S one-bit delay: bit_cnt == 0 is the cycle after the edge and carries the MSB.
- Good edge: edge while bit_cnt == SLOT_WIDTH-1.
- Early error: edge while bit_cnt != SLOT_WIDTH-1.
- Late error: bit_cnt == SLOT_WIDTH-1 with no edge.
- Error checking is active in TRAIN, LOCKED and DRAIN only.
- Strobes are decoded from registered state with zero latency relative to rx_bit, and are asserted only in LOCKED or DRAIN:
  - shift_en = bit_cnt < I2S_WIDTH
  - word_done = bit_cnt == I2S_WIDTH-1, gated off in any error cycle
  - word_lr = slot_lr
  - frame_start = (bit_cnt == 0) && !slot_lr
- FSM states and transitions:
  - IDLE: enable=1 -> SEEK.
  - SEEK: falling edge -> TRAIN, good_cnt <= 0. enable=0 -> IDLE.
  - TRAIN: each good edge increments good_cnt. When good_cnt reaches 2*LOCK_FRAMES -> LOCKED (always on a falling edge, so the first word out is L). Error -> SEEK plus frame_err. enable=0 -> IDLE.
  - LOCKED: error -> SEEK plus frame_err; strobes are suppressed in the error cycle and the partial word is dropped. enable=0 -> DRAIN.
  - DRAIN: strobes continue until the next edge, then -> IDLE. The in-flight word completes; no new word starts. Error -> IDLE plus frame_err.
- locked changes in the cycle after the state transition.
- Reset mid-word: all state clears immediately; no word_done is ever emitted for the partial word.
- Simultaneous error and enable=0: the error transition wins.

Optional Feature:
Macro I2S_RX_ERR_CNT_EN.
- Defined: adds output port err_cnt [7:0]. It increments on every frame_err, saturates at 255 and is cleared only by sys_rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package i2s_rx_pkg:
  - rx_state_t enum {IDLE, SEEK, TRAIN, LOCKED, DRAIN}
  - ERR_CNT_W = 8
  - helper function cnt_w(SLOT_WIDTH) = $clog2(SLOT_WIDTH+1)
- Sub-module i2s_lr_edge_det: input registers plus edge and falling-edge flags; reused by the future TX framer.

Test Plan:
1. Clean stream (SLOT_WIDTH=32, I2S_WIDTH=24, LOCK_FRAMES=2), L=0xA5A5A5, R=0x5A5A5A, enable=1 -> locked rises after 4 good edges. Per word: shift_en high for exactly 24 cycles and word_done once. Reassembled L/R match the stimulus; the first frame_start follows a falling edge.
2. Half-frame of 31 BCLKs injected while locked -> frame_err pulses once at the early edge; no word_done in that slot; locked=0; re-lock after 2 clean frames.
3. Half-frame of 33 BCLKs -> frame_err at bit_cnt=31 with no edge; word_done is suppressed when I2S_WIDTH=32.
4. enable dropped at bit 10 of an R word -> that word still produces word_done with word_lr=1; then state is IDLE, locked=0 and no further strobes.
5. sys_rst pulsed at bit 12 -> all outputs 0 within the same cycle; no word_done for the partial word; lock is reacquired after release.
6. With I2S_RX_ERR_CNT_EN defined, 300 injected errors -> err_cnt == 255.
